fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 Parameter IMEM_BYTES, default 128, the size of instruction memory in bytes; the legal fetch range is 0 to IMEM_BYTES-4.
REQ-003 Parameter NOP_INSN, default 32'h0000_0013, the instruction injected into IF/ID on flush or fault.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  from hazard unit; holds the PC and IF/ID contents.
REQ-007 redirect  input  1  branch/jump taken, resolved downstream.
REQ-008 redirect_pc  input  32  target address for redirect.
REQ-009 pc  output  32  current fetch address, driven combinationally to the instruction memory.
REQ-010 instruction  input  32  fetched word returned combinationally by the instruction memory for pc.
REQ-011 ifid_pc  output  32  PC of the instruction held in IF/ID.
REQ-012 ifid_insn  output  32  instruction held in IF/ID.
REQ-013 ifid_valid  output  1  IF/ID holds a real instruction.
REQ-014 fault  output  1  sticky flag for a misaligned or out-of-range fetch.

Function
REQ-015 The FSM shall have the states RUN, HOLD and HALT, encoded in 2 bits.
- RUN: redirect taken -> RUN; stall=1 and redirect=0 -> HOLD; fault detected -> HALT.
- HOLD: stall=0 -> RUN; redirect taken -> RUN; fault detected -> HALT.
- HALT: no exit except reset.
REQ-016 In RUN with stall=0, each cycle shall load pc <= pc+4, ifid_pc <= pc, ifid_insn <= instruction and ifid_valid <= 1.
- The instruction returns in the same cycle, so fetch-to-IF/ID latency is 1 cycle.
REQ-017 With stall=1, pc, ifid_pc, ifid_insn and ifid_valid shall hold their values.
REQ-018 With redirect=1, the block shall load pc <= redirect_pc, ifid_insn <= NOP_INSN and ifid_valid <= 0 next cycle, overriding stall.
REQ-019 If redirect and stall are asserted together, redirect shall win; the state shall go to RUN.
REQ-020 A fault shall be detected when pc[1:0] != 0 or pc > IMEM_BYTES-4, evaluated on the current pc while the state is not HALT.
REQ-021 On a fault, the block shall set fault <= 1, load ifid_insn <= NOP_INSN and ifid_valid <= 0, and enter HALT with pc frozen.
REQ-022 A redirect to a faulting target shall be accepted; the fault is then raised on the following cycle.
REQ-023 The PC adder shall be 32-bit and wrap modulo 2^32 with no carry-out; any wrapped value is out of range and faults per REQ-020.
REQ-024 In HALT, stall and redirect shall be ignored and all outputs held.

Reset
REQ-025 Reset shall asynchronously force: pc=RESET_PC, ifid_pc=0, ifid_insn=NOP_INSN, ifid_valid=0, fault=0, state=RUN.
REQ-026 On the first rising edge after reset deassertion, the block shall capture the instruction at RESET_PC into IF/ID.
REQ-027 Reset asserted mid-stall or mid-redirect shall abort the operation; no partial update shall remain.

Structure
REQ-028 The shared package cpu_pkg shall hold the FSM state encodings, NOP_INSN and the RESET_PC default, for reuse by decode and the hazard unit.
REQ-029 The PC register and next-PC mux shall be the single sub-module pc_reg (inputs: stall, redirect, redirect_pc, halt); the FSM and IF/ID register shall stay in fetch_unit.
REQ-030 The block shall contain no memory; it connects to the instruction memory via pc/instruction only.

Verification
REQ-031 Reset release with a preloaded memory, 4 cycles -> ifid_pc sequence 0,4,8,12; ifid_valid=1 from cycle 1.
REQ-032 stall=1 for 3 cycles at pc=8 -> pc stays 8, IF/ID holds the pc=4 word; resumes at 12 after release.
REQ-033 redirect=1, redirect_pc=0x40 with stall=1 the same cycle -> next pc=0x40, ifid_valid=0, ifid_insn=0x00000013.
REQ-034 redirect_pc=0x42 -> next cycle fault=1, state HALT, pc frozen at 0x42; further redirects ignored.
REQ-035 Sequential run to pc=0x7C, then step -> pc=0x80 raises fault (IMEM_BYTES=128).
REQ-036 rst pulsed asynchronously mid-HOLD between clock edges -> outputs take reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by fetch, decode and the hazard unit.
//   fetch_state_e  - fetch FSM encoding (RUN / HOLD / HALT, 2 bits)
//   CPU_NOP_INSN   - bubble instruction injected on flush or fault (addi x0,x0,0)
//   CPU_RESET_PC   - default PC loaded on reset
//   fetch_addr_bad - misaligned / out-of-range test for a fetch address
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] CPU_NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

  // Legal fetches are word aligned and lie in [0, imem_bytes-4].
  function automatic logic fetch_addr_bad(input logic [31:0] addr,
                                          input logic [31:0] imem_bytes);
    return (addr[1:0] != 2'b00) || (addr > (imem_bytes - 32'd4));
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program counter and next-PC mux.
//   clk, rst     - clock, async active-high reset (loads RESET_PC)
//   stall        - hold PC
//   redirect     - load redirect_pc (beats stall)
//   redirect_pc  - redirect target
//   halt         - freeze PC unconditionally (fault / HALT)
//   pc           - current fetch address
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else if (!halt) begin
      if (redirect)
        pc <= redirect_pc;
      else if (!stall)
        pc <= pc + 32'd4;  // wraps mod 2^32; a wrapped PC is out of range and faults
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with IF/ID register.
//   clk, rst          - clock, async active-high reset
//   stall             - hazard hold of PC and IF/ID
//   redirect, redirect_pc - taken branch/jump from downstream
//   pc                - fetch address to instruction memory
//   instruction       - word returned combinationally for pc
//   ifid_pc, ifid_insn, ifid_valid - IF/ID register
//   fault             - sticky bad-fetch flag; block halts until reset
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = CPU_RESET_PC,
  parameter int unsigned IMEM_BYTES = 128,
  parameter logic [31:0] NOP_INSN   = CPU_NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_insn,
  output logic        ifid_valid,
  output logic        fault
);

  fetch_state_e state_q, state_d;
  logic fault_det, ld_ifid, kill_ifid, set_fault, pc_halt;

  // Checked on the current PC, so a redirect to a bad target is taken
  // first and faults on the following cycle.
  assign fault_det = (state_q != ST_HALT) && fetch_addr_bad(pc, 32'(IMEM_BYTES));
  assign pc_halt   = (state_q == ST_HALT) || fault_det;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (pc_halt),
    .pc         (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Priority: fault > redirect > stall > advance. HALT is absorbing.
  always_comb begin
    state_d   = state_q;
    ld_ifid   = 1'b0;
    kill_ifid = 1'b0;
    set_fault = 1'b0;
    unique case (state_q)
      ST_RUN, ST_HOLD: begin
        if (fault_det) begin
          state_d   = ST_HALT;
          kill_ifid = 1'b1;
          set_fault = 1'b1;
        end else if (redirect) begin
          state_d   = ST_RUN;
          kill_ifid = 1'b1;
        end else if (stall) begin
          state_d   = ST_HOLD;
        end else begin
          state_d   = ST_RUN;
          ld_ifid   = 1'b1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;  // illegal encoding: park safely
    endcase
  end

  // IF/ID register; ifid_pc is left untouched by a kill since valid=0 marks it stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_pc    <= 32'd0;
      ifid_insn  <= NOP_INSN;
      ifid_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      if (kill_ifid) begin
        ifid_insn  <= NOP_INSN;
        ifid_valid <= 1'b0;
      end else if (ld_ifid) begin
        ifid_pc    <= pc;
        ifid_insn  <= instruction;
        ifid_valid <= 1'b1;
      end
      if (set_fault) fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver applies one input vector per
// cycle, advances a behavioural model and queues the expected post-edge
// outputs; the monitor pops and compares just after every rising edge.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned IMB = 128;

  logic        clk, rst, stall, redirect;
  logic [31:0] redirect_pc, pc, instruction, ifid_pc, ifid_insn;
  logic        ifid_valid, fault;

  logic [31:0] mem [32];
  assign instruction = mem[pc[6:2]];

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(pc), .instruction(instruction),
    .ifid_pc(ifid_pc), .ifid_insn(ifid_insn), .ifid_valid(ifid_valid),
    .fault(fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc, ipc, insn;
    logic        vld, flt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;

  // reference model state
  logic [31:0] m_pc, m_ipc, m_insn;
  logic        m_vld, m_flt, m_halt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_ipc = 32'd0; m_insn = NOP; m_vld = 1'b0; m_flt = 1'b0; m_halt = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_pc", pc, 32'd0);
    chk("rst_ifid_pc", ifid_pc, 32'd0);
    chk("rst_ifid_insn", ifid_insn, NOP);
    chk("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
  endtask

  // One clock of stimulus; the model states what the block must do.
  task automatic step(input logic s, input logic r, input logic [31:0] rp);
    exp_t e;
    @(negedge clk);
    rst = 1'b0; stall = s; redirect = r; redirect_pc = rp;
    if (!m_halt) begin
      if (m_pc % 4 != 0 || m_pc > IMB - 4) begin
        m_flt = 1'b1; m_vld = 1'b0; m_insn = NOP; m_halt = 1'b1;
      end else if (r) begin
        m_pc = rp; m_vld = 1'b0; m_insn = NOP;
      end else if (!s) begin
        m_ipc = m_pc; m_insn = mem[m_pc / 4]; m_vld = 1'b1; m_pc = m_pc + 4;
      end
    end
    e.pc = m_pc; e.ipc = m_ipc; e.insn = m_insn; e.vld = m_vld; e.flt = m_flt;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    #1 check_reset_outputs();
    model_reset();
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 3))
      0, 1:    return {25'd0, 5'($urandom_range(0, 31)), 2'b00};
      2:       return {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
      default: return 32'h80 + 32'($urandom_range(0, 255));
    endcase
  endfunction

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("ifid_pc", ifid_pc, e.ipc);
        chk("ifid_insn", ifid_insn, e.insn);
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.vld});
        chk("fault", {31'd0, fault}, {31'd0, e.flt});
      end
    end
  end

  // driver
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    model_reset();
    #1 check_reset_outputs();

    // sequential fetch, stall at pc=8, resume
    step(0, 0, 0); step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0);

    // redirect beats a simultaneous stall
    step(1, 1, 32'h40);
    // run 0x40..0x7C then step onto 0x80 -> fault, then redirects ignored
    repeat (18) step(0, 0, 0);
    step(0, 1, 32'h10); step(1, 1, 32'h20); step(0, 0, 0);

    // misaligned redirect target faults one cycle later
    do_reset();
    step(0, 0, 0); step(0, 1, 32'h42); step(0, 0, 0);
    step(0, 1, 32'h8); step(0, 0, 0);

    // async reset mid-HOLD, observed before any clock edge
    do_reset();
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs();
    model_reset();
    step(0, 0, 0); step(0, 0, 0);

    // randomized rounds
    for (int rnd = 0; rnd < 6; rnd++) begin
      do_reset();
      for (int c = 0; c < 50; c++) begin
        logic s, r;
        s = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 9) == 0);
        step(s, r, rand_target());
      end
    end

    // drain, bounded
    for (int w = 0; w < 4 && q.size() > 0; w++) @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
